cdb_arbiter: RTL and testbench

Completion arbiter between the functional units and the common data bus. Each FU hands one result at a time through a valid/ready handshake into a private holding register. A round-robin scheduler grants up to `WAYS` held results per cycle onto the registered CDB slots, which drive the ROB's `CDB_*` inputs and the RS/PRF wakeup. On `proc_nuke`, all in-flight results are discarded.

---
 rtl/cdb_arbiter_pkg.sv | 21 ++
 rtl/cdb_rr_picker.sv | 43 ++++
 rtl/cdb_arbiter.sv | 109 ++++++++++
 tb/tb_cdb_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared completion-bus definitions: machine constants and the CDB result
// payload used by the arbiter, ROB, RS and PRF write ports.
package cdb_arbiter_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB       = 32;
  localparam int unsigned PRF       = 64;
  localparam int unsigned CDB_WAYS  = 2;
  localparam int unsigned ROB_IDX_W = $clog2(ROB);
  localparam int unsigned PRN_IDX_W = $clog2(PRF);

  // One completed result as broadcast on a CDB slot.
  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PRN_IDX_W-1:0] prn;
    logic [XLEN-1:0]      value;
    logic                 direction;
    logic [XLEN-1:0]      target;
  } cdb_packet;

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational circular multi-grant selector.
// Scans req starting at rr_ptr (wrapping) and grants the first WAYS set bits.
//   req      : request vector (held holding registers)
//   rr_ptr   : scan start index
//   grant    : granted requesters
//   sel      : per-slot one-hot select; scan order k maps to slot k
//   last_idx : index of the last granted requester (rr_ptr when none)
module cdb_rr_picker #(
  parameter int unsigned NUM_FU = 6,
  parameter int unsigned WAYS   = 2
) (
  input  logic [NUM_FU-1:0]            req,
  input  logic [$clog2(NUM_FU)-1:0]    rr_ptr,
  output logic [NUM_FU-1:0]            grant,
  output logic [WAYS-1:0][NUM_FU-1:0]  sel,
  output logic [$clog2(NUM_FU)-1:0]    last_idx
);

  localparam int unsigned PTR_W  = $clog2(NUM_FU);
  localparam int unsigned SLOT_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Walk every position once from rr_ptr, filling slots in scan order.
  always_comb begin
    int unsigned idx;
    int unsigned cnt;
    grant    = '0;
    sel      = '0;
    last_idx = rr_ptr;
    cnt      = 0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (req[PTR_W'(idx)] && (cnt < WAYS)) begin
        grant[PTR_W'(idx)]                   = 1'b1;
        sel[SLOT_W'(cnt)][PTR_W'(idx)]       = 1'b1;
        last_idx                             = PTR_W'(idx);
        cnt                                  = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Completion arbiter between functional units and the common data bus.
// Each FU hands one result into a private holding register; a round-robin
// picker grants up to WAYS held results per cycle onto registered CDB slots.
//   clock, reset (async active-low), proc_nuke (sync flush)
//   fu_valid/fu_packet/fu_ready : per-FU valid/ready result handshake
//   CDB_valid/CDB_packet        : registered CDB slots
//   num_held                    : registered count of occupied holding regs
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU = 6,
  parameter int unsigned WAYS   = CDB_WAYS,
  parameter int unsigned ROB_W  = ROB_IDX_W,
  parameter int unsigned PRN_W  = PRN_IDX_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       proc_nuke,
  input  logic      [NUM_FU-1:0]     fu_valid,
  input  cdb_packet [NUM_FU-1:0]     fu_packet,
  output logic      [NUM_FU-1:0]     fu_ready,
  output logic      [WAYS-1:0]       CDB_valid,
  output cdb_packet [WAYS-1:0]       CDB_packet,
  output logic      [$clog2(NUM_FU):0] num_held
);

  localparam int unsigned PTR_W = $clog2(NUM_FU);
  localparam int unsigned CNT_W = $clog2(NUM_FU) + 1;

  // The payload layout lives in the package; the index widths must agree.
  if ((WAYS == 0) || (WAYS > NUM_FU)) begin : g_bad_ways
    $error("cdb_arbiter: WAYS must be in 1..NUM_FU");
  end
  if ((ROB_W != ROB_IDX_W) || (PRN_W != PRN_IDX_W)) begin : g_bad_width
    $error("cdb_arbiter: ROB_W/PRN_W disagree with cdb_packet");
  end

  logic      [NUM_FU-1:0]           held_q, held_d, grant, xfer;
  cdb_packet [NUM_FU-1:0]           hold_pkt_q;
  logic      [PTR_W-1:0]            rr_ptr_q, rr_ptr_d, last_idx;
  logic      [WAYS-1:0][NUM_FU-1:0] sel;
  logic      [WAYS-1:0]             cdb_valid_d;
  cdb_packet [WAYS-1:0]             cdb_packet_d;
  logic      [CNT_W-1:0]            num_held_d;

  cdb_rr_picker #(
    .NUM_FU (NUM_FU),
    .WAYS   (WAYS)
  ) u_picker (
    .req      (held_q),
    .rr_ptr   (rr_ptr_q),
    .grant    (grant),
    .sel      (sel),
    .last_idx (last_idx)
  );

  // A granted register drains this cycle, so it can refill at the same edge.
  assign fu_ready = {NUM_FU{!proc_nuke}} & (~held_q | grant);
  assign xfer     = fu_valid & fu_ready;

  // Next holding state, pointer, CDB slot contents and occupancy count.
  always_comb begin
    held_d       = (held_q & ~grant) | xfer;
    rr_ptr_d     = rr_ptr_q;
    cdb_valid_d  = '0;
    cdb_packet_d = '0;
    num_held_d   = '0;
    if (|grant) begin
      rr_ptr_d = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + PTR_W'(1);
    end
    for (int unsigned k = 0; k < WAYS; k++) begin
      cdb_valid_d[k] = |sel[k];
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (sel[k][i]) cdb_packet_d[k] = hold_pkt_q[i];
      end
    end
    if (proc_nuke) begin
      held_d       = '0;
      rr_ptr_d     = '0;
      cdb_valid_d  = '0;
      cdb_packet_d = '0;
    end
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      num_held_d = num_held_d + CNT_W'(held_d[i]);
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held_q     <= '0;
      hold_pkt_q <= '0;
      rr_ptr_q   <= '0;
      CDB_valid  <= '0;
      CDB_packet <= '0;
      num_held   <= '0;
    end else begin
      held_q     <= held_d;
      rr_ptr_q   <= rr_ptr_d;
      CDB_valid  <= cdb_valid_d;
      CDB_packet <= cdb_packet_d;
      num_held   <= num_held_d;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (xfer[i]) hold_pkt_q[i] <= fu_packet[i];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (NUM_FU=6, WAYS=2): constant vector
// table, hand sequences for reset/latency/back-pressure, and randomized
// traffic against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NF = 6;
  localparam int NW = 2;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  proc_nuke = 1'b0;
  logic      [NF-1:0]    fu_valid = '0;
  cdb_packet [NF-1:0]    fu_packet = '0;
  logic      [NF-1:0]    fu_ready;
  logic      [NW-1:0]    CDB_valid;
  cdb_packet [NW-1:0]    CDB_packet;
  logic      [3:0]       num_held;

  cdb_arbiter #(.NUM_FU(NF), .WAYS(NW)) dut (
    .clock      (clock),
    .reset      (reset),
    .proc_nuke  (proc_nuke),
    .fu_valid   (fu_valid),
    .fu_packet  (fu_packet),
    .fu_ready   (fu_ready),
    .CDB_valid  (CDB_valid),
    .CDB_packet (CDB_packet),
    .num_held   (num_held)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy + stored packet per FU, scan start pointer.
  cdb_packet   m_pkt [NF];
  bit          m_held[NF];
  int          m_ptr;
  logic [NF-1:0] m_xfer;

  function automatic void m_reset();
    for (int i = 0; i < NF; i++) begin
      m_held[i] = 1'b0;
      m_pkt[i]  = '0;
    end
    m_ptr  = 0;
    m_xfer = '0;
  endfunction

  function automatic cdb_packet mk_pkt(input int i);
    cdb_packet p;
    p.rob_idx   = ROB_IDX_W'(i + 3);
    p.prn       = PRN_IDX_W'(i + 8);
    p.value     = 32'hA000_0000 + 32'(i);
    p.direction = 1'(i);
    p.target    = 32'h1000 + 32'(4 * i);
    return p;
  endfunction

  function automatic cdb_packet rnd_pkt();
    cdb_packet p;
    p.rob_idx   = ROB_IDX_W'($urandom);
    p.prn       = PRN_IDX_W'($urandom);
    p.value     = $urandom;
    p.direction = 1'($urandom);
    p.target    = $urandom;
    return p;
  endfunction

  // One clock: check fu_ready, advance the model, check registered outputs.
  task automatic tick();
    int gq[$];
    logic [NF-1:0] gmask;
    logic [NF-1:0] rdy;
    logic [NW-1:0] e_valid;
    cdb_packet     e_pkt[NW];
    bit            e_nuke;
    int            e_num;
    int            idx;
    #1;
    gmask = '0;
    for (int k = 0; k < NF; k++) begin
      idx = (m_ptr + k) % NF;
      if (m_held[idx] && gq.size() < NW) begin
        gq.push_back(idx);
        gmask[idx] = 1'b1;
      end
    end
    for (int i = 0; i < NF; i++) rdy[i] = !proc_nuke && (!m_held[i] || gmask[i]);
    chk("fu_ready", 128'(fu_ready), 128'(rdy));
    m_xfer  = fu_valid & rdy;
    e_nuke  = proc_nuke;
    e_valid = '0;
    for (int k = 0; k < NW; k++) e_pkt[k] = '0;
    if (proc_nuke) begin
      for (int i = 0; i < NF; i++) m_held[i] = 1'b0;
      m_ptr = 0;
    end else begin
      for (int k = 0; k < gq.size(); k++) begin
        e_valid[k]    = 1'b1;
        e_pkt[k]      = m_pkt[gq[k]];
        m_held[gq[k]] = 1'b0;
      end
      if (gq.size() > 0) m_ptr = (gq[gq.size() - 1] + 1) % NF;
      for (int i = 0; i < NF; i++) begin
        if (m_xfer[i]) begin
          m_held[i] = 1'b1;
          m_pkt[i]  = fu_packet[i];
        end
      end
    end
    e_num = 0;
    for (int i = 0; i < NF; i++) e_num += int'(m_held[i]);
    @(posedge clock);
    #1;
    chk("CDB_valid", 128'(CDB_valid), 128'(e_valid));
    if (!e_nuke) begin
      for (int k = 0; k < NW; k++) chk("CDB_packet", 128'(CDB_packet[k]), 128'(e_pkt[k]));
    end
    chk("num_held", 128'(num_held), 128'(e_num));
  endtask

  typedef struct {
    logic [NF-1:0] fv;
    logic          nuke;
    logic [NF-1:0] rdy;
    logic [NW-1:0] vld;
    int            s0;
    int            s1;
    int            num;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cdb_packet exp_p;
    cdb_packet single;
    int seq[NF];
    int rx1, gap, max_gap;
    bit saw_bp, seen;

    // contention, wrap-around, pointer and nuke vectors (from reset state)
    tbl[0]  = '{6'b111111, 1'b0, 6'b111111, 2'b00, -1, -1, 6};
    tbl[1]  = '{6'b000000, 1'b0, 6'b000011, 2'b11,  0,  1, 4};
    tbl[2]  = '{6'b000000, 1'b0, 6'b001111, 2'b11,  2,  3, 2};
    tbl[3]  = '{6'b000000, 1'b0, 6'b111111, 2'b11,  4,  5, 0};
    tbl[4]  = '{6'b000000, 1'b0, 6'b111111, 2'b00, -1, -1, 0};
    tbl[5]  = '{6'b010000, 1'b0, 6'b111111, 2'b00, -1, -1, 1};
    tbl[6]  = '{6'b101001, 1'b0, 6'b111111, 2'b01,  4, -1, 3};
    tbl[7]  = '{6'b000000, 1'b0, 6'b110111, 2'b11,  5,  0, 1};
    tbl[8]  = '{6'b000000, 1'b0, 6'b111111, 2'b01,  3, -1, 0};
    tbl[9]  = '{6'b010001, 1'b0, 6'b111111, 2'b00, -1, -1, 2};
    tbl[10] = '{6'b000000, 1'b0, 6'b111111, 2'b11,  4,  0, 0};
    tbl[11] = '{6'b111100, 1'b0, 6'b111111, 2'b00, -1, -1, 4};
    tbl[12] = '{6'b000001, 1'b1, 6'b000000, 2'b00, -1, -1, 0};
    tbl[13] = '{6'b000000, 1'b0, 6'b111111, 2'b00, -1, -1, 0};
    tbl[14] = '{6'b100001, 1'b0, 6'b111111, 2'b00, -1, -1, 2};
    tbl[15] = '{6'b000000, 1'b0, 6'b111111, 2'b11,  0,  5, 0};

    // reset state
    m_reset();
    @(posedge clock);
    #1;
    chk("rst_CDB_valid", 128'(CDB_valid), 128'(0));
    chk("rst_num_held", 128'(num_held), 128'(0));
    chk("rst_fu_ready", 128'(fu_ready), 128'(6'b111111));
    @(posedge clock);
    #3;
    reset = 1'b1;

    // table-driven vectors
    for (int i = 0; i < NF; i++) fu_packet[i] = mk_pkt(i);
    for (int r = 0; r < 16; r++) begin
      fu_valid  = tbl[r].fv;
      proc_nuke = tbl[r].nuke;
      #1;
      chk($sformatf("tbl%0d_ready", r), 128'(fu_ready), 128'(tbl[r].rdy));
      tick();
      chk($sformatf("tbl%0d_valid", r), 128'(CDB_valid), 128'(tbl[r].vld));
      chk($sformatf("tbl%0d_num", r), 128'(num_held), 128'(tbl[r].num));
      if (!tbl[r].nuke) begin
        exp_p = (tbl[r].s0 < 0) ? cdb_packet'(0) : mk_pkt(tbl[r].s0);
        chk($sformatf("tbl%0d_slot0", r), 128'(CDB_packet[0]), 128'(exp_p));
        exp_p = (tbl[r].s1 < 0) ? cdb_packet'(0) : mk_pkt(tbl[r].s1);
        chk($sformatf("tbl%0d_slot1", r), 128'(CDB_packet[1]), 128'(exp_p));
      end
    end
    proc_nuke = 1'b0;

    // single result: FU2, 2-cycle latency, slot 1 idle
    single = '0;
    single.rob_idx = ROB_IDX_W'(5);
    single.prn     = PRN_IDX_W'(17);
    single.value   = 32'hDEADBEEF;
    fu_packet[2] = single;
    fu_valid     = 6'b000100;
    tick();
    chk("single_lat1_valid", 128'(CDB_valid), 128'(0));
    fu_valid = '0;
    tick();
    chk("single_valid", 128'(CDB_valid), 128'(2'b01));
    chk("single_slot0", 128'(CDB_packet[0]), 128'(single));
    chk("single_slot1", 128'(CDB_packet[1]), 128'(0));

    // reset mid-traffic with 3 held and CDB active
    for (int i = 0; i < NF; i++) fu_packet[i] = mk_pkt(i);
    fu_valid = 6'b011111;
    tick();
    fu_valid = '0;
    tick();
    chk("prerst_num", 128'(num_held), 128'(3));
    fu_valid = 6'b100000;
    #2;
    reset = 1'b0;
    m_reset();
    #1;
    chk("rst_imm_valid", 128'(CDB_valid), 128'(0));
    chk("rst_imm_num", 128'(num_held), 128'(0));
    chk("rst_imm_pkt", 128'(CDB_packet), 128'(0));
    chk("rst_imm_ready", 128'(fu_ready), 128'(6'b111111));
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_hold_num", 128'(num_held), 128'(0));
    #2;
    reset = 1'b1;
    fu_valid = 6'b001000;
    tick();
    chk("rst_first_lat1", 128'(CDB_valid), 128'(0));
    fu_valid = '0;
    tick();
    chk("rst_first_valid", 128'(CDB_valid), 128'(2'b01));
    chk("rst_first_pkt", 128'(CDB_packet[0]), 128'(mk_pkt(3)));

    // back-pressure: all FUs stream; FU1 tagged sequence must arrive intact
    for (int i = 0; i < NF; i++) begin
      seq[i] = 0;
      fu_packet[i] = mk_pkt(i);
      fu_packet[i].value = {8'(i), 24'(0)};
    end
    rx1 = 0; gap = 0; max_gap = 0; saw_bp = 0;
    fu_valid = '1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!m_xfer[1]) saw_bp = 1;
      for (int i = 0; i < NF; i++) begin
        if (m_xfer[i]) begin
          seq[i]++;
          fu_packet[i].value = {8'(i), 24'(seq[i])};
        end
      end
      seen = 0;
      for (int k = 0; k < NW; k++) begin
        if (CDB_valid[k] && CDB_packet[k].value[31:24] == 8'd1) begin
          chk("bp_order", 128'(CDB_packet[k].value[23:0]), 128'(rx1));
          rx1++;
          seen = 1;
        end
      end
      if (c > 0) begin
        gap++;
        if (seen) begin
          if (gap > max_gap) max_gap = gap;
          gap = 0;
        end
      end
    end
    fu_valid = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int k = 0; k < NW; k++) begin
        if (CDB_valid[k] && CDB_packet[k].value[31:24] == 8'd1) begin
          chk("bp_order", 128'(CDB_packet[k].value[23:0]), 128'(rx1));
          rx1++;
        end
      end
    end
    chk("bp_count", 128'(rx1), 128'(seq[1]));
    chk("bp_seen_backpressure", 128'(saw_bp), 128'(1));
    chk("bp_gap_le3", 128'(max_gap <= 3), 128'(1));

    // randomized traffic with occasional nukes
    for (int c = 0; c < 400; c++) begin
      proc_nuke = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < NF; i++) begin
        if (!fu_valid[i] || m_xfer[i]) begin
          fu_valid[i]  = ($urandom_range(0, 2) != 0);
          fu_packet[i] = rnd_pkt();
        end
      end
      tick();
    end
    proc_nuke = 1'b0;
    fu_valid  = '0;
    for (int c = 0; c < 5; c++) tick();
    chk("drain_num", 128'(num_held), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
